// File: rtl/hammer_multi.sv
// hammer_multi: whack-a-mole hammer for N_HOLES holes, with any number of moles up at once.
// The switches are edge-detected. Each new strike is scored as a hit or a miss, and the
// hit and miss counters saturate instead of wrapping. A miss starts a lockout window,
// and switches are ignored until it expires.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | game not running, no scoring
//   ST_ARMED   | scoring new switch edges against mole_mask
//   ST_LOCKOUT | penalty window after a miss, edges ignored
module hammer_multi #(
   parameter int N_HOLES        = 18,
   parameter int COUNT_W        = 12,
   parameter int LOCKOUT_CYCLES = 50
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               clear,
   input  logic [N_HOLES-1:0] switches,
   input  logic [N_HOLES-1:0] mole_mask,
   output logic               hit,
   output logic               miss,
   output logic [N_HOLES-1:0] hit_mask,
   output logic [COUNT_W-1:0] hit_count,
   output logic [COUNT_W-1:0] miss_count,
   output logic               locked
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_LOCKOUT = 2'd2;

   // lock_cnt only ever holds LOCKOUT_CYCLES-1 down to 0
   localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam int PC_W   = $clog2(N_HOLES + 1);
   localparam bit LOCK_EN = (LOCKOUT_CYCLES > 0);
   localparam logic [LOCK_W-1:0] LOCK_INIT =
      LOCK_W'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);

   logic [1:0]          state_q, state_d;
   logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
   logic [N_HOLES-1:0]  sw_q;
   logic                hit_q, hit_d;
   logic                miss_q, miss_d;
   logic [N_HOLES-1:0]  hit_mask_q, hit_mask_d;
   logic [COUNT_W-1:0]  hit_cnt_q, hit_cnt_d;
   logic [COUNT_W-1:0]  miss_cnt_q, miss_cnt_d;

   logic [N_HOLES-1:0]  edges, hit_e, miss_e;

   function automatic logic [PC_W-1:0] popcnt(input logic [N_HOLES-1:0] v);
      logic [PC_W-1:0] c;
      c = '0;
      for (int i = 0; i < N_HOLES; i++) begin
         c = c + PC_W'(v[i]);
      end
      return c;
   endfunction

   function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] a,
                                                  input logic [PC_W-1:0]    b);
      logic [COUNT_W:0] s;
      s = {1'b0, a} + (COUNT_W+1)'(b);
      return s[COUNT_W] ? {COUNT_W{1'b1}} : s[COUNT_W-1:0];
   endfunction

   // A switch that is already high when scoring starts never produces an edge,
   // because sw_q tracks the switches in every state.
   assign edges  = switches & ~sw_q;
   assign hit_e  = edges & mole_mask;
   assign miss_e = edges & ~mole_mask;

   // Next-state, scoring and lockout timer logic
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      hit_d      = 1'b0;
      miss_d     = 1'b0;
      hit_mask_d = '0;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;

      if (clear) begin
         hit_cnt_d  = '0;
         miss_cnt_d = '0;
         lock_cnt_d = '0;
         state_d    = enable ? ST_ARMED : ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable) state_d = ST_ARMED;
            end
            ST_ARMED: begin
               if (!enable) begin
                  state_d = ST_IDLE;
               end else begin
                  hit_d      = |hit_e;
                  miss_d     = |miss_e;
                  hit_mask_d = hit_e;
                  hit_cnt_d  = sat_add(hit_cnt_q, popcnt(hit_e));
                  miss_cnt_d = sat_add(miss_cnt_q, popcnt(miss_e));
                  // Simultaneous hits are still scored above; the miss wins the state change
                  if (LOCK_EN && (|miss_e)) begin
                     state_d    = ST_LOCKOUT;
                     lock_cnt_d = LOCK_INIT;
                  end
               end
            end
            ST_LOCKOUT: begin
               if (!enable) begin
                  state_d    = ST_IDLE;
                  lock_cnt_d = '0;
               end else if (lock_cnt_q == '0) begin
                  state_d = ST_ARMED;
               end else begin
                  lock_cnt_d = lock_cnt_q - LOCK_W'(1);
               end
            end
            default: begin
               state_d    = ST_IDLE;
               lock_cnt_d = '0;
            end
         endcase
      end
   end

   // State, switch history, pulses and counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         lock_cnt_q <= '0;
         sw_q       <= '0;
         hit_q      <= 1'b0;
         miss_q     <= 1'b0;
         hit_mask_q <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         sw_q       <= switches;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
         hit_mask_q <= hit_mask_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit        = hit_q;
   assign miss       = miss_q;
   assign hit_mask   = hit_mask_q;
   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
   assign locked     = (state_q == ST_LOCKOUT);

endmodule

// File: tb/tb_hammer_multi.sv
// Bench for hammer_multi: directed scenarios plus random play against a behavioural model.
module tb_hammer_multi;

   localparam int N    = 18;
   localparam int CW   = 12;
   localparam int L    = 50;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          clear;
   logic [N-1:0]  switches;
   logic [N-1:0]  mole_mask;
   logic          hit, miss, locked;
   logic [N-1:0]  hit_mask;
   logic [CW-1:0] hit_count, miss_count;

   int total = 0;
   int bad   = 0;

   // Behavioural model: mode 0 idle, 1 armed, 2 locked with m_remain cycles left
   logic [N-1:0] m_swq, m_mask;
   logic         m_hit, m_miss;
   int           m_mode, m_remain, m_hc, m_mc;

   hammer_multi #(.N_HOLES(N), .COUNT_W(CW), .LOCKOUT_CYCLES(L)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .clear      (clear),
      .switches   (switches),
      .mole_mask  (mole_mask),
      .hit        (hit),
      .miss       (miss),
      .hit_mask   (hit_mask),
      .hit_count  (hit_count),
      .miss_count (miss_count),
      .locked     (locked)
   );

   always #5 clk = ~clk;

   function automatic int minc(input int a);
      return (a > MAXC) ? MAXC : a;
   endfunction

   task automatic model_reset();
      m_swq = '0; m_mask = '0; m_hit = 1'b0; m_miss = 1'b0;
      m_mode = 0; m_remain = 0; m_hc = 0; m_mc = 0;
   endtask

   task automatic model_step();
      logic [N-1:0] e, h, ms;
      e  = switches & ~m_swq;
      h  = e & mole_mask;
      ms = e & ~mole_mask;
      m_hit = 1'b0; m_miss = 1'b0; m_mask = '0;
      if (clear) begin
         m_hc = 0; m_mc = 0; m_remain = 0;
         m_mode = enable ? 1 : 0;
      end else if (m_mode == 0) begin
         if (enable) m_mode = 1;
      end else if (m_mode == 1) begin
         if (!enable) m_mode = 0;
         else begin
            m_mask = h;
            m_hit  = (h != '0);
            m_miss = (ms != '0);
            m_hc   = minc(m_hc + $countones(h));
            m_mc   = minc(m_mc + $countones(ms));
            if (ms != '0 && L > 0) begin
               m_mode   = 2;
               m_remain = L;
            end
         end
      end else begin
         if (!enable) m_mode = 0;
         else begin
            m_remain--;
            if (m_remain == 0) m_mode = 1;
         end
      end
      m_swq = switches;
   endtask

   task automatic drive(input logic [N-1:0] sw, input logic [N-1:0] mm,
                        input logic en, input logic clr);
      switches  = sw;
      mole_mask = mm;
      enable    = en;
      clear     = clr;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; enable = 1'b0; clear = 1'b0; switches = '0; mole_mask = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++; if (hit !== 1'b0)      begin bad++; $display("FAIL reset_hit got=%0b want=0", hit); end
      total++; if (miss !== 1'b0)     begin bad++; $display("FAIL reset_miss got=%0b want=0", miss); end
      total++; if (hit_mask !== '0)   begin bad++; $display("FAIL reset_hit_mask got=%h want=0", hit_mask); end
      total++; if (hit_count !== '0)  begin bad++; $display("FAIL reset_hit_count got=%0d want=0", hit_count); end
      total++; if (miss_count !== '0) begin bad++; $display("FAIL reset_miss_count got=%0d want=0", miss_count); end
      total++; if (locked !== 1'b0)   begin bad++; $display("FAIL reset_locked got=%0b want=0", locked); end
   endtask

   task automatic test_single_hit();
      drive('0, '0, 1'b1, 1'b0);
      drive(18'h1, 18'h1, 1'b1, 1'b0);
      total++; if (hit !== 1'b1)          begin bad++; $display("FAIL single_hit_pulse got=%0b want=1", hit); end
      total++; if (hit_mask !== 18'h1)    begin bad++; $display("FAIL single_hit_mask got=%h want=1", hit_mask); end
      total++; if (hit_count !== 12'd1)   begin bad++; $display("FAIL single_hit_count got=%0d want=1", hit_count); end
      total++; if (miss !== 1'b0)         begin bad++; $display("FAIL single_hit_nomiss got=%0b want=0", miss); end
      for (int i = 0; i < 3; i++) begin
         drive(18'h1, 18'h1, 1'b1, 1'b0);
         total++; if (hit !== 1'b0 || hit_count !== 12'd1)
            begin bad++; $display("FAIL single_hit_held hit=%0b count=%0d want hit=0 count=1", hit, hit_count); end
      end
   endtask

   task automatic test_miss_lockout();
      int cnt;
      int hc0;
      drive('0, '0, 1'b1, 1'b0);
      hc0 = m_hc;
      drive(18'h4, '0, 1'b1, 1'b0);
      total++; if (miss !== 1'b1)       begin bad++; $display("FAIL lock_miss_pulse got=%0b want=1", miss); end
      total++; if (miss_count !== 12'd1) begin bad++; $display("FAIL lock_miss_count got=%0d want=1", miss_count); end
      cnt = 0;
      while (locked === 1'b1 && cnt < 3 * L) begin
         cnt++;
         if (cnt == 10) drive(18'h4 | 18'h8, 18'h8, 1'b1, 1'b0);
         else if (cnt > 10) drive(18'h4 | 18'h8, 18'h8, 1'b1, 1'b0);
         else drive(18'h4, 18'h8, 1'b1, 1'b0);
         total++; if (hit !== 1'b0 || miss !== 1'b0)
            begin bad++; $display("FAIL lock_ignored cyc=%0d hit=%0b miss=%0b want 0 0", cnt, hit, miss); end
      end
      total++; if (cnt !== L) begin bad++; $display("FAIL lock_length got=%0d want=%0d", cnt, L); end
      drive(18'hC, 18'h8, 1'b1, 1'b0);
      total++; if (hit_count !== 12'(hc0) || miss_count !== 12'd1)
         begin bad++; $display("FAIL lock_held_exit hc=%0d mc=%0d want hc=%0d mc=1", hit_count, miss_count, hc0); end
   endtask

   task automatic test_multi_hit();
      int hc0;
      drive('0, 18'h92, 1'b1, 1'b0);
      hc0 = m_hc;
      drive(18'h92, 18'h92, 1'b1, 1'b0);
      total++; if (hit !== 1'b1)                 begin bad++; $display("FAIL multi_hit_pulse got=%0b want=1", hit); end
      total++; if (hit_mask !== 18'h92)          begin bad++; $display("FAIL multi_hit_mask got=%h want=92", hit_mask); end
      total++; if (hit_count !== 12'(hc0 + 3))   begin bad++; $display("FAIL multi_hit_count got=%0d want=%0d", hit_count, hc0 + 3); end
      drive('0, 18'h92, 1'b1, 1'b0);
      total++; if (hit_mask !== '0)              begin bad++; $display("FAIL multi_hit_mask_clear got=%h want=0", hit_mask); end
   endtask

   task automatic test_saturation();
      drive('0, '1, 1'b1, 1'b1);
      total++; if (hit_count !== '0) begin bad++; $display("FAIL sat_clear got=%0d want=0", hit_count); end
      for (int i = 0; i < 227; i++) begin
         drive('1, '1, 1'b1, 1'b0);
         drive('0, '1, 1'b1, 1'b0);
      end
      drive(18'hFF, '1, 1'b1, 1'b0);
      drive('0, '1, 1'b1, 1'b0);
      total++; if (hit_count !== 12'd4094) begin bad++; $display("FAIL sat_preload got=%0d want=4094", hit_count); end
      drive(18'h7, '1, 1'b1, 1'b0);
      total++; if (hit_count !== 12'd4095 || hit !== 1'b1)
         begin bad++; $display("FAIL sat_reach got=%0d hit=%0b want=4095 1", hit_count, hit); end
      drive('0, '1, 1'b1, 1'b0);
      drive('1, '1, 1'b1, 1'b0);
      total++; if (hit_count !== 12'd4095) begin bad++; $display("FAIL sat_hold got=%0d want=4095", hit_count); end
   endtask

   task automatic test_async_reset();
      drive('0, '0, 1'b1, 1'b0);
      drive(18'h4, '0, 1'b1, 1'b0);
      drive(18'h4, '0, 1'b1, 1'b0);
      total++; if (locked !== 1'b1 || miss_count === '0 || hit_count === '0)
         begin bad++; $display("FAIL areset_setup locked=%0b hc=%0d mc=%0d", locked, hit_count, miss_count); end
      #2 reset = 1'b0;
      #1;
      model_reset();
      total++; if (locked !== 1'b0 || hit_count !== '0 || miss_count !== '0 || hit !== 1'b0 || miss !== 1'b0 || hit_mask !== '0)
         begin bad++; $display("FAIL areset_immediate locked=%0b hc=%0d mc=%0d hit=%0b miss=%0b mask=%h want all 0",
                               locked, hit_count, miss_count, hit, miss, hit_mask); end
      switches = '1; mole_mask = '1; enable = 1'b1; clear = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive('1, '1, 1'b1, 1'b0);
         total++; if (hit !== 1'b0 || hit_count !== '0)
            begin bad++; $display("FAIL areset_held_sw cyc=%0d hit=%0b hc=%0d want 0 0", i, hit, hit_count); end
      end
   endtask

   task automatic test_enable_clear();
      drive('0, 18'h20, 1'b1, 1'b0);
      drive(18'h20, 18'h20, 1'b1, 1'b0);
      drive('0, 18'h20, 1'b0, 1'b0);
      drive('0, 18'h20, 1'b0, 1'b0);
      drive(18'h20, 18'h20, 1'b0, 1'b0);
      total++; if (hit !== 1'b0 || hit_count !== 12'd1)
         begin bad++; $display("FAIL en_off_no_hit hit=%0b hc=%0d want 0 1", hit, hit_count); end
      for (int i = 0; i < 3; i++) begin
         drive(18'h20, 18'h20, 1'b1, 1'b0);
         total++; if (hit !== 1'b0 || hit_count !== 12'd1)
            begin bad++; $display("FAIL en_on_held cyc=%0d hit=%0b hc=%0d want 0 1", i, hit, hit_count); end
      end
      drive(18'h20, 18'h20, 1'b1, 1'b1);
      total++; if (hit_count !== '0 || miss_count !== '0)
         begin bad++; $display("FAIL clear_counts hc=%0d mc=%0d want 0 0", hit_count, miss_count); end
   endtask

   task automatic test_random();
      logic [N-1:0] sw;
      sw = switches;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 2) == 0) sw = sw ^ (N'(1) << $urandom_range(0, N - 1));
         if ($urandom_range(0, 7) == 0) sw = sw & N'($urandom);
         drive(sw, N'($urandom), ($urandom_range(0, 29) != 0), ($urandom_range(0, 79) == 0));
         total++;
         if (hit !== m_hit || miss !== m_miss || hit_mask !== m_mask || hit_count !== 12'(m_hc) ||
             miss_count !== 12'(m_mc) || locked !== (m_mode == 2)) begin
            bad++;
            $display("FAIL random cyc=%0d got hit=%0b miss=%0b mask=%h hc=%0d mc=%0d lk=%0b want hit=%0b miss=%0b mask=%h hc=%0d mc=%0d lk=%0b",
                     c, hit, miss, hit_mask, hit_count, miss_count, locked,
                     m_hit, m_miss, m_mask, m_hc, m_mc, (m_mode == 2));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_hit();
      test_miss_lockout();
      test_multi_hit();
      test_saturation();
      test_async_reset();
      test_enable_clear();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
